aes_word_io: RTL and testbench

AES_WORD_IO -- requirements
Module: aes_word_io

---
 rtl/aes_word_io.sv | 127 ++++++++++++
 tb/tb_aes_word_io.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_word_io.sv
// Word-serial wrapper around an AES-128 core: gathers key and plaintext as 32-bit words,
// runs the core under a timeout watchdog, then streams the ciphertext back out as words.
module aes_word_io #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_word_i,
  output logic         core_rst_no,
  output logic [127:0] core_key_o,
  output logic [127:0] core_plaintext_o,
  input  logic         core_finish_i,
  input  logic [127:0] core_text_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_word_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [2:0]     wc_q, wc_d;
  logic [1:0]     oc_q, oc_d;
  logic [15:0]    cc_q, cc_d;
  logic           err_q, err_d;
  logic [127:0]   key_q, pt_q, buf_q;
  logic           buf_we;
  logic           in_fire, out_fire, timeout;
  logic [3:0]     key_we, pt_we;

  assign in_fire  = (state_q == S_LOAD) && in_valid_i;
  assign out_fire = (state_q == S_DRAIN) && out_ready_i;
  assign timeout  = (cc_q == 16'(TIMEOUT_CYCLES - 1));

  // Word counter 0-3 addresses key lanes, 4-7 plaintext lanes, MS word first.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_we
      assign key_we[gi] = in_fire && (wc_q == 3'(gi));
      assign pt_we[gi]  = in_fire && (wc_q == 3'(gi + 4));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    oc_d    = oc_q;
    cc_d    = cc_q;
    err_d   = err_q;
    buf_we  = 1'b0;
    case (state_q)
      S_LOAD: begin
        cc_d = '0;
        if (in_fire) begin
          wc_d = wc_q + 3'd1;
          if (wc_q == 3'd7) state_d = S_RUN;
        end
      end
      S_RUN: begin
        cc_d = cc_q + 16'd1;
        // A finish arriving on the timeout cycle still counts as success.
        if (core_finish_i) begin
          buf_we  = 1'b1;
          state_d = S_DRAIN;
        end else if (timeout) begin
          err_d   = 1'b1;
          wc_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        cc_d = '0;
        if (out_fire) begin
          oc_d = oc_q + 2'd1;
          if (oc_q == 2'd3) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_LOAD;
      wc_q    <= '0;
      oc_q    <= '0;
      cc_q    <= '0;
      err_q   <= 1'b0;
      key_q   <= '0;
      pt_q    <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      oc_q    <= oc_d;
      cc_q    <= cc_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) begin
        if (key_we[i]) key_q[127-32*i -: 32] <= in_word_i;
        if (pt_we[i])  pt_q[127-32*i -: 32]  <= in_word_i;
      end
      if (buf_we) buf_q <= core_text_i;
    end
  end

  always_comb begin
    case (oc_q)
      2'd0:    out_word_o = buf_q[127:96];
      2'd1:    out_word_o = buf_q[95:64];
      2'd2:    out_word_o = buf_q[63:32];
      default: out_word_o = buf_q[31:0];
    endcase
  end

  assign in_ready_o       = (state_q == S_LOAD);
  assign core_rst_no      = (state_q == S_RUN);
  assign out_valid_o      = (state_q == S_DRAIN);
  assign busy_o           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign err_o            = err_q;
  assign core_key_o       = key_q;
  assign core_plaintext_o = pt_q;

endmodule

// File: tb/tb_aes_word_io.sv
// Bench for aes_word_io: a core stand-in answers FIPS-197 exactly and a simple keyed mix otherwise.
module tb_aes_word_io;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic [7:0][31:0] w;
    logic [7:0]       lat;
    logic [1:0]       bp;
    logic             gap;
    logic [3:0][31:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_word = '0;
  logic         out_ready = 1'b0;
  logic         in_ready_o, core_rst_no, out_valid_o, busy_o, err_o;
  logic [127:0] core_key_o, core_plaintext_o, core_text;
  logic [31:0]  out_word_o;
  logic         core_finish;

  logic         core_en = 1'b1;
  logic         force_fin = 1'b0;
  int           core_lat = 0;
  int           core_cnt = 0;
  int           checks = 0;
  int           errors = 0;
  logic         exp_err = 1'b0;
  vec_t         tbl [8];
  vec_t         fips;

  aes_word_io #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_word_i(in_word),
    .core_rst_no(core_rst_no), .core_key_o(core_key_o), .core_plaintext_o(core_plaintext_o),
    .core_finish_i(core_finish), .core_text_i(core_text),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_word_o(out_word_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_text(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5_0f0f_3c3c_9696_5a5a_f0f0_c3c3_6969;
  endfunction

  // Core stand-in: restarts while core_rst_no is low, finishes core_lat cycles into a run.
  always @(posedge clk) begin
    if (!core_rst_no) core_cnt <= 0;
    else              core_cnt <= core_cnt + 1;
  end
  assign core_finish = force_fin | (core_en && core_rst_no && (core_cnt == core_lat));
  assign core_text   = ref_text(core_key_o, core_plaintext_o);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] key_of(input vec_t v);
    return {v.w[0], v.w[1], v.w[2], v.w[3]};
  endfunction
  function automatic logic [127:0] pt_of(input vec_t v);
    return {v.w[4], v.w[5], v.w[6], v.w[7]};
  endfunction

  function automatic vec_t make_vec(input logic [127:0] k, input logic [127:0] p,
                                    input int lat, input int bp, input bit gap);
    vec_t v;
    logic [127:0] ct;
    ct = ref_text(k, p);
    for (int j = 0; j < 4; j++) begin
      v.w[j]   = k[127-32*j -: 32];
      v.w[j+4] = p[127-32*j -: 32];
      v.exp[j] = ct[127-32*j -: 32];
    end
    v.lat = 8'(lat);
    v.bp  = 2'(bp);
    v.gap = gap;
    return v;
  endfunction

  task automatic feed(input vec_t v, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      if (v.gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      chk("load_ready", {127'd0, in_ready_o}, 128'd1);
      in_valid = 1'b1;
      in_word  = v.w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    exp_err = 1'b0;
  endtask

  // Runs one block; stop_after < 4 leaves the DUT in DRAIN after that many words.
  task automatic run_block(input vec_t v, input int idx, input int stop_after);
    int  n;
    bit  prev_fin, key_stable;
    core_lat = int'(v.lat);
    feed(v, 8);
    chk("run_entry_busy", {127'd0, busy_o}, 128'd1);
    chk("run_entry_ready", {127'd0, in_ready_o}, 128'd0);
    chk("run_entry_corerst", {127'd0, core_rst_no}, 128'd1);
    chk("key_assembled", core_key_o, key_of(v));
    chk("pt_assembled", core_plaintext_o, pt_of(v));
    n = 0; prev_fin = 1'b0; key_stable = 1'b1;
    while (!out_valid_o && n < 200) begin
      if (core_key_o !== key_of(v) || core_plaintext_o !== pt_of(v)) key_stable = 1'b0;
      prev_fin = core_finish;
      @(negedge clk);
      n++;
    end
    chk("out_valid_arrives", {127'd0, out_valid_o}, 128'd1);
    chk("finish_to_valid", {127'd0, prev_fin}, 128'd1);
    chk("run_cycles", 128'(n), 128'(int'(v.lat) + 1));
    chk("key_stable_run", {127'd0, key_stable}, 128'd1);
    for (int k = 0; k < stop_after; k++) begin
      for (int b = 0; b < int'(v.bp); b++) begin
        out_ready = 1'b0;
        chk("hold_valid", {127'd0, out_valid_o}, 128'd1);
        chk("hold_word", {96'd0, out_word_o}, {96'd0, v.exp[k]});
        @(negedge clk);
      end
      out_ready = 1'b1;
      chk("drain_valid", {127'd0, out_valid_o}, 128'd1);
      chk("drain_word", {96'd0, out_word_o}, {96'd0, v.exp[k]});
      @(negedge clk);
      out_ready = 1'b0;
    end
    if (stop_after == 4) begin
      chk("post_valid", {127'd0, out_valid_o}, 128'd0);
      chk("post_ready", {127'd0, in_ready_o}, 128'd1);
      chk("post_busy", {127'd0, busy_o}, 128'd0);
      chk("post_buf_word0", {96'd0, out_word_o}, {96'd0, v.exp[0]});
      @(negedge clk);
      chk("no_extra_valid", {127'd0, out_valid_o}, 128'd0);
    end
    chk("err_flag", {127'd0, err_o}, {127'd0, exp_err});
    $display("block %0d lat=%0d bp=%0d gap=%0d words=%0d out0=%h", idx, v.lat, v.bp, v.gap,
             stop_after, v.exp[0]);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {127'd0, out_valid_o}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy_o}, 128'd0);
    chk({tag, "_corerst"}, {127'd0, core_rst_no}, 128'd0);
    chk({tag, "_err"}, {127'd0, err_o}, 128'd0);
    chk({tag, "_key"}, core_key_o, 128'd0);
    chk({tag, "_pt"}, core_plaintext_o, 128'd0);
    chk({tag, "_word"}, {96'd0, out_word_o}, 128'd0);
  endtask

  initial begin
    int  n;
    bit  saw_valid, early_err;
    fips = make_vec(FIPS_KEY, FIPS_PT, 5, 0, 1'b0);
    fips.exp = {32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};

    tbl[0] = fips;
    tbl[1] = fips; tbl[1].lat = 8'd3; tbl[1].bp = 2'd3; tbl[1].gap = 1'b1;
    tbl[2] = make_vec({$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, 63, 1, 1'b0);
    tbl[3] = make_vec({$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0);
    for (int i = 4; i < 8; i++)
      tbl[i] = make_vec({$urandom, $urandom, $urandom, $urandom},
                        {$urandom, $urandom, $urandom, $urandom},
                        int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    check_reset_state("reset");
    chk("reset_ready", {127'd0, in_ready_o}, 128'd1);

    for (int i = 0; i < 8; i++) run_block(tbl[i], i, 4);

    force_fin = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious_ready", {127'd0, in_ready_o}, 128'd1);
    chk("spurious_busy", {127'd0, busy_o}, 128'd0);
    chk("spurious_valid", {127'd0, out_valid_o}, 128'd0);
    chk("spurious_buf", {96'd0, out_word_o}, {96'd0, tbl[7].exp[0]});
    force_fin = 1'b0;
    run_block(tbl[4], 8, 4);

    feed(tbl[5], 3);
    do_reset();
    check_reset_state("partial_reset");
    run_block(fips, 9, 4);

    run_block(tbl[6], 10, 2);
    do_reset();
    check_reset_state("drain_reset");
    @(negedge clk);
    chk("drain_reset_later_valid", {127'd0, out_valid_o}, 128'd0);
    run_block(fips, 11, 4);

    core_en = 1'b0;
    feed(fips, 8);
    n = 0; saw_valid = 1'b0; early_err = 1'b0;
    while (busy_o && n < 200) begin
      if (out_valid_o) saw_valid = 1'b1;
      if (err_o) early_err = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("timeout_run_cycles", 128'(n), 128'd64);
    chk("timeout_err", {127'd0, err_o}, 128'd1);
    chk("timeout_no_early_err", {127'd0, early_err}, 128'd0);
    chk("timeout_no_valid", {127'd0, saw_valid}, 128'd0);
    chk("timeout_ready", {127'd0, in_ready_o}, 128'd1);
    $display("timeout block run_cycles=%0d err=%0b", n, err_o);
    exp_err = 1'b1;
    core_en = 1'b1;
    run_block(fips, 12, 4);
    do_reset();
    chk("err_cleared", {127'd0, err_o}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
